pipe_stage_buf: RTL and testbench

- Parametrised inter-stage pipeline buffer for the five-stage MIPS core; generalises the fixed D/E latch.
- Configurable payload width and depth: 1 = plain stage register, 2..4 = skid/elastic buffer.
- Adds valid/ready handshake in place of a bare enable.
- Carries PC, exception code and branch-delay flag with flush-bubble and exception-redirect semantics: a bubble keeps the PC/BD that CP0 needs, and an exception request injects the handler PC.

---
 rtl/pipe_stage_buf_if.sv | 38 +++
 rtl/pipe_stage_buf.sv | 136 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: handshake and payload bundle around one pipe_stage_buf.
//   master : the instantiating stage. It drives the upstream entry, out_ready and flush/req,
//            and it observes in_ready, the head entry and count.
//   slave  : the buffer itself.
// Parameters must match the pipe_stage_buf instance that the bundle is connected to.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned EXC_W  = 5,
    parameter int unsigned DEPTH  = 1
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;
    logic [EXC_W-1:0]  in_excode;
    logic              in_bd;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;
    logic [EXC_W-1:0]  out_excode;
    logic              out_bd;
    logic              flush;
    logic              req;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_pc, in_data, in_excode, in_bd, out_ready, flush, req,
        input  in_ready, out_valid, out_pc, out_data, out_excode, out_bd, count
    );

    modport slave (
        input  in_valid, in_pc, in_data, in_excode, in_bd, out_ready, flush, req,
        output in_ready, out_valid, out_pc, out_data, out_excode, out_bd, count
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage buffer for the five-stage core.
//   DEPTH == 1 acts as a stall-able stage register. DEPTH 2..4 acts as a skid/elastic FIFO.
//   Each entry holds {pc, data, excode, bd}. When the buffer is empty, the outputs present a
//   bubble whose PC/BD come from the bubble register, so that CP0 still sees a valid EPC source.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : pipe_stage_buf_if.slave, which carries the in_*/out_* handshake, flush, req and count
module pipe_stage_buf #(
    parameter int unsigned DATA_W  = 160,
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned EXC_W   = 5,
    parameter logic [31:0] EXC_VEC = 32'h00004180
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_buf_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       bpc_q, bpc_d;
    logic              bbd_q, bbd_d;

    logic [31:0]       pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [EXC_W-1:0]  exc_mem  [DEPTH];
    logic              bd_mem   [DEPTH];

    logic ready;
    logic valid;
    logic push;
    logic pop;
    logic wr_en;

    // Wrap modulo DEPTH, so that depths that are not a power of two also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // in_ready depends only on the registered count, so there is no path from out_ready.
    assign ready = (count_q < CNT_W'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = bus.in_valid & ready;
    assign pop   = valid & bus.out_ready;
    assign wr_en = push & ~bus.req & ~bus.flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        bpc_d   = bpc_q;
        bbd_d   = bbd_q;
        if (bus.req) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            bpc_d   = EXC_VEC;
            bbd_d   = 1'b0;
        end else if (bus.flush) begin
            // The bubble inherits the PC/BD of the instruction that was killed upstream.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            bpc_d   = bus.in_pc;
            bbd_d   = bus.in_bd;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // The last entry leaves: the bubble remembers its PC for later exceptions.
            if (pop && !push && count_q == CNT_W'(1)) begin
                bpc_d = pc_mem[head_q];
                bbd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            bpc_q   <= '0;
            bbd_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            bpc_q   <= bpc_d;
            bbd_q   <= bbd_d;
        end
    end

    // Payload storage is not reset. Empty slots are never presented at the outputs.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            pc_mem[tail_q]   <= bus.in_pc;
            data_mem[tail_q] <= bus.in_data;
            exc_mem[tail_q]  <= bus.in_excode;
            bd_mem[tail_q]   <= bus.in_bd;
        end
    end

    always_comb begin
        bus.out_pc     = bpc_q;
        bus.out_bd     = bbd_q;
        bus.out_data   = '0;
        bus.out_excode = '0;
        if (valid) begin
            bus.out_pc     = pc_mem[head_q];
            bus.out_bd     = bd_mem[head_q];
            bus.out_data   = data_mem[head_q];
            bus.out_excode = exc_mem[head_q];
        end
    end

    assign bus.out_valid = valid;
    assign bus.in_ready  = ready;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW), .DEPTH(2)) if2 ();
    pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW), .DEPTH(4)) if4 ();

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .EXC_W(EW), .EXC_VEC(32'h00004180)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(4), .EXC_W(EW), .EXC_VEC(32'h00004180)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return pc ^ 32'hA5A50000;
    endfunction

    function automatic logic [4:0] exc_of(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs depend only on registered state, so sampling 1 ns after the edge is stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [31:0] pc, input logic bd);
        if2.in_valid  = v;
        if2.in_pc     = pc;
        if2.in_data   = data_of(pc);
        if2.in_excode = exc_of(pc);
        if2.in_bd     = bd;
    endtask

    task automatic drive4(input logic v, input logic [31:0] pc);
        if4.in_valid  = v;
        if4.in_pc     = pc;
        if4.in_data   = data_of(pc);
        if4.in_excode = exc_of(pc);
        if4.in_bd     = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        drive2(1'b0, 32'h0, 1'b0);
        drive4(1'b0, 32'h0);
        if2.out_ready = 1'b0; if2.flush = 1'b0; if2.req = 1'b0;
        if4.out_ready = 1'b0; if4.flush = 1'b0; if4.req = 1'b0;

        // Reset state
        step();
        check("rst_valid", if2.out_valid, 0);
        check("rst_pc", if2.out_pc, 0);
        check("rst_data", if2.out_data, 0);
        check("rst_exc", if2.out_excode, 0);
        check("rst_bd", if2.out_bd, 0);
        check("rst_ready", if2.in_ready, 1);
        check("rst_count", if2.count, 0);
        reset = 1'b1;

        // Streaming with out_ready=1: one-cycle latency, count stays at 1
        if2.out_ready = 1'b1;
        drive2(1'b1, 32'h3000, 1'b0);
        step();
        check("s0_valid", if2.out_valid, 1);
        check("s0_pc", if2.out_pc, 32'h3000);
        check("s0_count", if2.count, 1);
        check("s0_ready", if2.in_ready, 1);
        drive2(1'b1, 32'h3004, 1'b0);
        step();
        check("s1_pc", if2.out_pc, 32'h3004);
        check("s1_count", if2.count, 1);
        drive2(1'b1, 32'h3008, 1'b0);
        step();
        check("s2_pc", if2.out_pc, 32'h3008);
        check("s2_data", if2.out_data, 32'hA5A53008);
        check("s2_exc", if2.out_excode, 5'd2);
        check("s2_count", if2.count, 1);
        drive2(1'b0, 32'h0, 1'b0);
        step();
        check("s3_valid", if2.out_valid, 0);
        check("s3_bpc", if2.out_pc, 32'h3008);
        check("s3_data", if2.out_data, 0);
        check("s3_count", if2.count, 0);

        // Backpressure: fill to 2, the third push is held
        if2.out_ready = 1'b0;
        drive2(1'b1, 32'h3000, 1'b0);
        step();
        drive2(1'b1, 32'h3004, 1'b0);
        step();
        check("bp_count2", if2.count, 2);
        check("bp_ready0", if2.in_ready, 0);
        drive2(1'b1, 32'h3008, 1'b0);
        step();
        check("bp_held_count", if2.count, 2);
        check("bp_held_pc", if2.out_pc, 32'h3000);
        if2.out_ready = 1'b1;
        step();
        check("bp_pop1_pc", if2.out_pc, 32'h3004);
        check("bp_pop1_count", if2.count, 1);
        check("bp_pop1_ready", if2.in_ready, 1);
        step();
        check("bp_pop2_pc", if2.out_pc, 32'h3008);
        check("bp_pop2_count", if2.count, 1);
        drive2(1'b0, 32'h0, 1'b0);
        step();
        check("bp_empty", if2.count, 0);

        // Flush keeps upstream PC/BD in the bubble
        if2.out_ready = 1'b0;
        drive2(1'b1, 32'h3010, 1'b1);
        step();
        check("fl_pre_pc", if2.out_pc, 32'h3010);
        check("fl_pre_bd", if2.out_bd, 1);
        drive2(1'b1, 32'h3014, 1'b1);
        if2.flush = 1'b1;
        step();
        if2.flush = 1'b0;
        check("fl_valid", if2.out_valid, 0);
        check("fl_pc", if2.out_pc, 32'h3014);
        check("fl_bd", if2.out_bd, 1);
        check("fl_data", if2.out_data, 0);
        check("fl_count", if2.count, 0);

        // req wins over flush: the bubble carries EXC_VEC
        drive2(1'b1, 32'h3018, 1'b1);
        step();
        drive2(1'b1, 32'h3020, 1'b1);
        if2.flush = 1'b1;
        if2.req   = 1'b1;
        step();
        if2.flush = 1'b0;
        if2.req   = 1'b0;
        check("rq_pc", if2.out_pc, 32'h00004180);
        check("rq_bd", if2.out_bd, 0);
        check("rq_exc", if2.out_excode, 0);
        check("rq_count", if2.count, 0);
        drive2(1'b1, 32'h4180, 1'b0);
        step();
        check("rq_push_valid", if2.out_valid, 1);
        check("rq_push_pc", if2.out_pc, 32'h4180);
        check("rq_push_count", if2.count, 1);
        drive2(1'b0, 32'h0, 1'b0);
        if2.out_ready = 1'b1;
        step();
        check("rq_drain", if2.count, 0);

        // DEPTH=4: fill, then push+pop for 8 cycles so that both pointers wrap twice
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 32'h5000 + 32'(4 * i));
            step();
        end
        check("d4_full_count", if4.count, 4);
        check("d4_full_ready", if4.in_ready, 0);
        check("d4_full_pc", if4.out_pc, 32'h5000);
        if4.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            // Cycle 1 is rejected (full), so 0x5010 is presented again in cycle 2
            drive4(1'b1, (k <= 2) ? 32'h5010 : 32'h5010 + 32'(4 * (k - 2)));
            step();
            check($sformatf("d4_pc_%0d", k), if4.out_pc, 32'h5000 + 32'(4 * k));
            check($sformatf("d4_cnt_%0d", k), if4.count, 3);
        end
        check("d4_data", if4.out_data, 32'hA5A55020);
        if4.out_ready = 1'b0;
        drive4(1'b0, 32'h0);

        // Reset mid-stream discards held entries
        if2.out_ready = 1'b0;
        drive2(1'b1, 32'h6000, 1'b0);
        step();
        drive2(1'b1, 32'h6004, 1'b1);
        step();
        check("mr_pre_count", if2.count, 2);
        drive2(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        step();
        check("mr_valid", if2.out_valid, 0);
        check("mr_pc", if2.out_pc, 0);
        check("mr_data", if2.out_data, 0);
        check("mr_exc", if2.out_excode, 0);
        check("mr_bd", if2.out_bd, 0);
        check("mr_ready", if2.in_ready, 1);
        check("mr_count", if2.count, 0);
        check("mr_d4_count", if4.count, 0);
        check("mr_d4_pc", if4.out_pc, 0);
        reset = 1'b1;
        drive2(1'b0, 32'h3000, 1'b0);
        if2.flush = 1'b1;
        step();
        if2.flush = 1'b0;
        check("mr_flush_pc", if2.out_pc, 32'h3000);
        check("mr_flush_count", if2.count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
